cla_multiword_add_ctrl: RTL and testbench

- Sequencer that time-multiplexes one 32-bit carry-lookahead adder (carry_lookahead_adder_32bit) to add WORDS×32-bit operands, one 32-bit word per cycle, LSW first.
- The carry is registered between words.
- Valid/ready handshake on input and output. Sits between wide-operand producers (e.g. crypto/bignum units) and the shared 32-bit CLA datapath.

---
 rtl/cla_ctrl_pkg.sv | 16 +
 rtl/cla_multiword_add_ctrl_cla32.sv | 40 ++++
 rtl/cla_multiword_add_ctrl.sv | 132 +++++++++++++
 tb/tb_cla_multiword_add_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_ctrl_pkg.sv
// Shared definitions for the multi-word CLA sequencer: word width and FSM state encoding.
package cla_ctrl_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/cla_multiword_add_ctrl_cla32.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate lookahead.
// Purely combinational datapath shared by the multi-word sequencer.
module carry_lookahead_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] p;
    logic [31:0] g;
    logic [32:0] c;
    logic        gg;
    logic        gp;

    // Bit-level P/G, in-group carries, and group-level carry lookahead.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gg = 1'b0;
        gp = 1'b1;
        c[0] = cin;
        for (int unsigned k = 0; k < 8; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int unsigned j = 0; j < 4; j++) begin
                gg = g[4*k+j] | (p[4*k+j] & gg);
                gp = gp & p[4*k+j];
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
            // Group carry-out taken from the lookahead terms, not the in-group chain.
            c[4*k+4] = gg | (gp & c[4*k]);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Multi-word add sequencer: feeds WORDS x 32-bit operands, LSW first, through one
// shared 32-bit CLA with the carry registered between words. Valid/ready on both sides.
// Optional subtract mode (op port) is enabled by defining CLA_MULTIWORD_SUB_EN.
module cla_multiword_add_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter  int unsigned WORDS = 4,
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned W     = WORD_W * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef CLA_MULTIWORD_SUB_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    ctrl_state_e                      state_q;
    logic [CNT_W-1:0]                 ctr_q;
    logic [WORDS-1:0][WORD_W-1:0]     a_q;
    logic [WORDS-1:0][WORD_W-1:0]     b_q;
    logic [WORDS-1:0][WORD_W-1:0]     sum_q;
    logic                             carry_q;
    logic                             in_ready_q;
    logic                             out_valid_q;
    logic                             busy_q;

    logic [WORD_W-1:0]                a_word;
    logic [WORD_W-1:0]                b_word;
    logic [WORD_W-1:0]                word_sum_d;
    logic                             word_cout_d;
    logic                             carry_init;

`ifdef CLA_MULTIWORD_SUB_EN
    logic                             op_q;
    // Subtraction: a + ~b + 1, so cout=1 means no borrow.
    assign b_word     = op_q ? ~b_q[ctr_q] : b_q[ctr_q];
    assign carry_init = op ? 1'b1 : cin;
`else
    assign b_word     = b_q[ctr_q];
    assign carry_init = cin;
`endif
    assign a_word = a_q[ctr_q];

    carry_lookahead_adder_32bit u_cla (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .sum  (word_sum_d),
        .cout (word_cout_d)
    );

    // FSM with counter, operand/result registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CLA_MULTIWORD_SUB_EN
            op_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= carry_init;
`ifdef CLA_MULTIWORD_SUB_EN
                        op_q       <= op;
`endif
                        ctr_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[ctr_q] <= word_sum_d;
                    carry_q      <= word_cout_d;
                    // Counter stops at the last word instead of wrapping.
                    if (ctr_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        ctr_q <= ctr_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Scoreboard bench for cla_multiword_add_ctrl with WORDS=4 (W=128).
module tb_cla_multiword_add_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_MULTIWORD_SUB_EN
    logic         op;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cla_multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_MULTIWORD_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on each output handshake.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %h with no expected entry", sum);
            end else begin
                e = exp_q.pop_front();
                chk("sum", {1'b0, sum}, {1'b0, e.s});
                chk("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, e.c});
            end
        end
    end

    // Monitor: result must not change while out_valid stays high.
    logic [W:0] held;
    logic       held_v = 1'b0;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held_v) chk("hold_stable", {cout, sum}, held);
            held   = {cout, sum};
            held_v = 1'b1;
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("wait_in_ready_timeout", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic opv, input logic [W-1:0] es, input logic ec);
        wait_ready();
        a = av; b = bv; cin = cv;
`ifdef CLA_MULTIWORD_SUB_EN
        op = opv;
`else
        if (opv) $display("note: op ignored in add-only build");
`endif
        in_valid = 1'b1;
        exp_q.push_back('{s: es, c: ec});
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs after acceptance; the operand copy must isolate the computation.
        a = ~av; b = ~bv; cin = ~cv;
        chk("busy_after_accept", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
        chk("out_valid_after_accept", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b0});
        for (int i = 1; i <= WORDS; i++) begin
            @(posedge clk); #1;
            chk("in_ready_busy", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b0});
            chk("out_valid_latency", {{W{1'b0}}, out_valid}, {{W{1'b0}}, (i == WORDS)});
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
`ifdef CLA_MULTIWORD_SUB_EN
        op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", {1'b0, sum}, '0);
        chk("rst_cout", {{W{1'b0}}, cout}, '0);
        chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("rst_busy", {{W{1'b0}}, busy}, '0);
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones + 1: carry through every word.
        run_op({W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1);
        @(posedge clk); #1;
        // Alternating patterns plus cin: carry ripples through all four registered words.
        run_op({4{32'hAAAAAAAA}}, {4{32'h55555555}}, 1'b1, 1'b0, 128'd0, 1'b1);
        @(posedge clk); #1;
        // Single inter-word carry.
        run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
               128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
        @(posedge clk); #1;
        // MSB overflow only.
        run_op(128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 128'd0, 1'b1);
        @(posedge clk); #1;
        // Small values with cin.
        run_op(128'd3, 128'd4, 1'b1, 1'b0, 128'd8, 1'b0);
        @(posedge clk); #1;

        // Backpressure: hold DONE for 6 cycles with a competing request pending.
        out_ready = 1'b0;
        run_op(128'h0000_0001_0000_0002_0000_0003_0000_0004,
               128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b0, 1'b0,
               128'h0000_0011_0000_0022_0000_0033_0000_0044, 1'b0);
        a = 128'd10; b = 128'd20; cin = 1'b0; in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {{W{1'b0}}, in_ready}, '0);
            chk("bp_out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        chk("bp_idle_out_valid", {{W{1'b0}}, out_valid}, '0);
        exp_q.push_back('{s: 128'd30, c: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
        repeat (WORDS) @(posedge clk);
        #1;
        chk("bp_second_done", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        @(posedge clk); #1;

        // Reset abort after two RUN edges.
        wait_ready();
        a = 128'd1000; b = 128'd1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("abort_sum", {1'b0, sum}, '0);
        chk("abort_cout", {{W{1'b0}}, cout}, '0);
        chk("abort_busy", {{W{1'b0}}, busy}, '0);
        chk("abort_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(128'd1, 128'd2, 1'b0, 1'b0, 128'd3, 1'b0);
        @(posedge clk); #1;

`ifdef CLA_MULTIWORD_SUB_EN
        // Subtraction: borrow case (cin ignored) and no-borrow case.
        run_op(128'd5, 128'd7, 1'b0, 1'b1, {{(W-1){1'b1}}, 1'b0}, 1'b0);
        @(posedge clk); #1;
        run_op(128'd7, 128'd5, 1'b1, 1'b1, 128'd2, 1'b1);
        @(posedge clk); #1;
        op = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
